ks_limb_mult_ctrl: RTL

- Sequential carry-less (GF(2)[x]) multiplier controller for the ECC field-arithmetic path.
- Splits W = 9*NLIMB-bit operands into 9-bit limbs.
- Time-shares one combinational ks9 Karatsuba instance, issuing one limb pair per cycle and XOR-accumulating shifted 17-bit partial products into a full-width product.
- Valid/ready handshakes on the operand side and the result side connect it to the field-reduction stage.

---
 rtl/ks_limb_mult_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ks_limb_mult_ctrl.sv
// Sequential carry-less (GF(2)[x]) limb multiplier controller.
// The operands are split into 9-bit limbs, and one combinational Karatsuba
// ks9 core is time-shared across all limb pairs, one pair per cycle.
// Each 17-bit partial product is shifted into place and XOR-accumulated
// into the full-width unreduced product.

// 9x9 carry-less Karatsuba core: 5-bit low halves and 4-bit high halves.
module ks9 (
    input  logic [8:0]  x,
    input  logic [8:0]  z,
    output logic [16:0] p
);

    // Plain shift-and-XOR product of two 5-bit polynomials.
    function automatic logic [8:0] clmul5(input logic [4:0] u, input logic [4:0] v);
        logic [8:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            if (v[k]) r = r ^ (9'(u) << k);
        end
        return r;
    endfunction

    logic [4:0] x_lo, x_hi, z_lo, z_hi;
    logic [8:0] p_lo, p_hi, p_mid, mid;

    // One Karatsuba level: three half-size products replace four.
    always_comb begin
        x_lo  = x[4:0];
        x_hi  = {1'b0, x[8:5]};
        z_lo  = z[4:0];
        z_hi  = {1'b0, z[8:5]};
        p_lo  = clmul5(x_lo, z_lo);
        p_hi  = clmul5(x_hi, z_hi);
        p_mid = clmul5(x_lo ^ x_hi, z_lo ^ z_hi);
        mid   = p_mid ^ p_lo ^ p_hi;
        p     = 17'(p_lo) ^ (17'(mid) << 5) ^ (17'(p_hi) << 10);
    end

endmodule

module ks_limb_mult_ctrl #(
    parameter  int NLIMB = 2,
    localparam int W     = 9 * NLIMB,
    localparam int PW    = 2 * W - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] y,
    output logic          busy
);

    localparam int IW = (NLIMB > 1) ? $clog2(NLIMB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NLIMB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_reg, b_reg;
    logic [PW-1:0] acc;
    logic [IW-1:0] i, j;

    logic [8:0]    a_limb, b_limb;
    logic [16:0]   ks_out;
    logic [PW-1:0] pp;
    int            shamt;

    ks9 u_ks9 (
        .x (a_limb),
        .z (b_limb),
        .p (ks_out)
    );

    // Select the current limb pair and place its product at bit 9*(i+j).
    always_comb begin
        a_limb = 9'(a_reg >> (9 * int'(i)));
        b_limb = 9'(b_reg >> (9 * int'(j)));
        shamt  = 9 * (int'(i) + int'(j));
        pp     = PW'(ks_out) << shamt;
    end

    // Accept when idle, or in HOLD when the consumer takes the result this edge.
    always_comb begin
        in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    end

    assign y = acc;

    // Control FSM: capture, walk limb pairs j-inner/i-outer, then hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc ^ pp;
                    if (j == LAST) begin
                        j <= '0;
                        if (i == LAST) begin
                            i         <= '0;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            a_reg <= a;
                            b_reg <= b;
                            acc   <= '0;
                            i     <= '0;
                            j     <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
